// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Memory-stage bus between the processor datapath and the data memory
//   responder.
//   master : processor side  (drives mem_read, mem_write, addr, wdata)
//   slave  : responder side  (drives rdata, ready, stall, err)
interface data_mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              stall;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, stall, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, stall, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory for the processor's memory stage. A load or
//   store request is held by the processor; the responder inserts
//   WAIT_CYCLES wait states, commits the access, then pulses ready for one
//   cycle with load data on rdata. stall holds the pipeline until then.
//   Requests with both strobes high are rejected with a one-cycle err pulse.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (clears state and memory)
//   bus    : slave side of data_mem_responder_if
//            mem_read/mem_write/addr/wdata in; rdata/ready/stall/err out
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; samples strobes, addr, wdata
// WAIT  | wait states; counter decrements, commit when it reaches 0
// DONE  | ready pulse for one cycle; requests ignored
//
// WAIT_CYCLES legal range: 0..15 (4-bit wait counter).
module data_mem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_one;
    logic              req_both;
    logic              accept;
    logic              commit;
    logic              commit_write;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_wdata;

    assign req_one  = bus.mem_read ^ bus.mem_write;
    assign req_both = bus.mem_read & bus.mem_write;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_one) begin
                    state_nxt = NO_WAIT ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt == 0 is unreachable in WAIT; treat it as terminal too
                if (cnt <= 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept       = (state == S_IDLE) && req_one;
        bus.stall    = accept || (state == S_WAIT);
        bus.ready    = (state == S_DONE);
        commit       = (accept && NO_WAIT) || ((state == S_WAIT) && (cnt <= 4'd1));
        // With no wait states the commit happens on the sample edge itself,
        // so the live request fields are used instead of the latched copies.
        if (state == S_WAIT) begin
            commit_write = op_write;
            commit_addr  = addr_q;
            commit_wdata = wdata_q;
        end else begin
            commit_write = bus.mem_write;
            commit_addr  = bus.addr;
            commit_wdata = bus.wdata;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;

    // Datapath: request latch, wait counter, memory array, load data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            err_q <= (state == S_IDLE) && req_both;

            if (accept) begin
                op_write <= bus.mem_write;
                addr_q   <= bus.addr;
                wdata_q  <= bus.wdata;
                cnt      <= WAIT_LD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                if (commit_write) begin
                    mem[commit_addr] <= commit_wdata;
                end else begin
                    rdata_q <= mem[commit_addr];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Two responder instances (2 wait states and 0 wait states) on a shared
//   clock and reset. Each access pushes the expected rdata and ready cycle
//   to a per-instance queue; a monitor pops and compares on every ready.
module tb_data_mem_responder;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [7:0] rd;
        int         at;
    } exp_t;

    exp_t       q2[$];
    exp_t       q0[$];
    logic [7:0] mem2_m [16];
    logic [7:0] mem0_m [16];
    logic [7:0] rd2_m;
    logic [7:0] rd0_m;

    data_mem_responder_if #(.DATA_W(8), .ADDR_W(4)) bus2 ();
    data_mem_responder_if #(.DATA_W(8), .ADDR_W(4)) bus0 ();

    data_mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    data_mem_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic stall_of(input int sel);
        return (sel == 0) ? bus0.stall : bus2.stall;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem2_m[i] = 8'h00;
            mem0_m[i] = 8'h00;
        end
        rd2_m = 8'h00;
        rd0_m = 8'h00;
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [3:0] a, input logic [7:0] d);
        if (sel == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.mem_read = rd; bus2.mem_write = wr; bus2.addr = a; bus2.wdata = d;
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge
    // that ends the ready cycle, i.e. where the next request may be presented.
    task automatic access(input int sel, input bit wr, input logic [3:0] a, input logic [7:0] d);
        int   w;
        exp_t e;
        w = (sel == 0) ? 0 : 2;
        drive(sel, !wr, wr, a, d);
        if (sel == 0) begin
            if (wr) mem0_m[a] = d; else rd0_m = mem0_m[a];
            e.rd = rd0_m;
        end else begin
            if (wr) mem2_m[a] = d; else rd2_m = mem2_m[a];
            e.rd = rd2_m;
        end
        e.at = cyc + 1 + w;
        if (sel == 0) q0.push_back(e); else q2.push_back(e);
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            check("stall_busy", stall_of(sel), 1'b1);
            @(posedge clk); #1;
            // Scramble the held fields after sampling; must have no effect.
            if (sel == 0) begin
                bus0.addr = 4'($urandom); bus0.wdata = 8'($urandom);
            end else begin
                bus2.addr = 4'($urandom); bus2.wdata = 8'($urandom);
            end
        end
        @(negedge clk);
        check("stall_ready", stall_of(sel), 1'b0);
        drive(sel, 1'b0, 1'b0, 4'h0, 8'h00);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (bus2.ready === 1'b1) begin
            if (q2.size() == 0) begin
                check("ready2_spurious", 32'(bus2.ready), 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("rdata2", 32'(bus2.rdata), 32'(e.rd));
                check("ready2_cycle", 32'(cyc), 32'(e.at));
            end
        end
        if (bus0.ready === 1'b1) begin
            if (q0.size() == 0) begin
                check("ready0_spurious", 32'(bus0.ready), 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("rdata0", 32'(bus0.rdata), 32'(e.rd));
                check("ready0_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(2, 1'b0, 1'b0, 4'h0, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_rdata2", 32'(bus2.rdata), 32'h00);
        check("rst_ready2", 32'(bus2.ready), 32'd0);
        check("rst_err2",   32'(bus2.err),   32'd0);
        check("rst_stall2", 32'(bus2.stall), 32'd0);
        check("rst_rdata0", 32'(bus0.rdata), 32'h00);
        check("rst_stall0", 32'(bus0.stall), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) access(2, 1'b0, 4'(i), 8'h00);

        // Store then load, 2 wait states
        access(2, 1'b1, 4'd3, 8'hA5);
        access(2, 1'b0, 4'd3, 8'h00);

        // Back-to-back
        access(2, 1'b1, 4'd15, 8'h3C);
        access(2, 1'b0, 4'd15, 8'h00);
        access(2, 1'b0, 4'd0,  8'h00);

        // Illegal request for one cycle
        drive(2, 1'b1, 1'b1, 4'd5, 8'hFF);
        @(negedge clk);
        check("illegal_stall", 32'(bus2.stall), 32'd0);
        @(posedge clk); #1;
        drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        check("illegal_err",   32'(bus2.err),   32'd1);
        check("illegal_ready", 32'(bus2.ready), 32'd0);
        check("illegal_stall_after", 32'(bus2.stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("illegal_err_once", 32'(bus2.err), 32'd0);
        @(posedge clk); #1;

        // Persistent illegal request re-pulses err
        drive(2, 1'b1, 1'b1, 4'd6, 8'h11);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("illegal_err_repeat", 32'(bus2.err), 32'd1);
        end
        drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
        @(posedge clk); #1;
        access(2, 1'b0, 4'd5, 8'h00);
        access(2, 1'b0, 4'd6, 8'h00);

        // Zero wait states
        access(0, 1'b1, 4'd1, 8'h12);
        access(0, 1'b0, 4'd1, 8'h00);

        // Reset in the first WAIT cycle of a store
        drive(2, 1'b0, 1'b1, 4'd2, 8'h77);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(2, 1'b0, 1'b0, 4'd0, 8'h00);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_stall", 32'(bus2.stall), 32'd0);
        check("midrst_rdata2", 32'(bus2.rdata), 32'h00);
        @(posedge clk); #1;
        access(2, 1'b0, 4'd2, 8'h00);
        access(0, 1'b0, 4'd1, 8'h00);

        // Random traffic on both instances
        for (int i = 0; i < 24; i++) begin
            access(2, 1'($urandom), 4'($urandom), 8'($urandom));
            access(0, 1'($urandom), 4'($urandom), 8'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        check("pending2", 32'(q2.size()), 32'd0);
        check("pending0", 32'(q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Single-port data memory that responds to the processor's load/store control strobes (MemRead, MemWrite) with a configurable wait-state handshake. It sits on the datapath's memory stage. It accepts a request whose address comes from the ALU result and whose write data comes from the second register operand. It holds the processor with a stall signal until the access commits, then pulses `ready` and presents read data for the MemtoReg path.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 4: address width; depth = 2^ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states inserted before commit; legal range 0–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mem_read`  in  1  load request; held by the processor until `ready`.
- `mem_write`  in  1  store request; held by the processor until `ready`.
- `addr`  in  ADDR_W  word address; held with the request.
- `wdata`  in  DATA_W  store data; held with the request.
- `rdata`  out  DATA_W  registered load data; valid from the `ready` cycle onward.
- `ready`  out  1  one-cycle pulse marking access completion.
- `stall`  out  1  combinational; holds the processor's PC and pipeline.
- `err`  out  1  one-cycle pulse when `mem_read` and `mem_write` are both sampled high.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, with exactly one of `mem_read`/`mem_write` high:
  - latch op, `addr`, `wdata`; load the wait counter with WAIT_CYCLES.
  - next state is WAIT, or DONE directly when WAIT_CYCLES = 0.
- IDLE, with both requests high:
  - no access; `err` = 1 next cycle; stay IDLE.
  - if the condition persists, `err` re-pulses every cycle.
- IDLE, no request: stay IDLE.
- WAIT: decrement the counter each cycle.
- Commit edge: the edge on which the counter reaches 0, or the IDLE sample edge when WAIT_CYCLES = 0. On this edge:
  - store: write the latched data to the latched address.
  - load: copy mem[latched address] into `rdata`.
  - enter DONE.
- DONE: `ready` = 1 for exactly one cycle, then unconditionally return to IDLE. Requests are ignored in DONE.
- Input sampling: the request is sampled only in IDLE. `addr`/`wdata` changes after the sample edge have no effect.
- `rdata`:
  - changes only on a load commit; a store leaves it unchanged.
  - holds its value otherwise.
- `stall` = (IDLE and exactly one request high) or WAIT. It is 0 in DONE, so the processor advances on the `ready` cycle.
- A store followed by a load of the same address returns the stored value; no forwarding is needed because accesses are serialized.
- Arithmetic:
  - the wait counter is 4 bits and never wraps below 0.
  - addresses cover the full 2^ADDR_W space; there is no out-of-range case.

## Timing
- Reset (sampled on an edge with `rst_n` = 0) produces:
  - state IDLE; `rdata` = 0, `ready` = 0, `err` = 0, counter = 0.
  - all memory words = 0.
  - `stall` then follows its combinational equation.
- Latency: a request first seen in IDLE during cycle t gives:
  - commit at the end of cycle t+WAIT_CYCLES;
  - `ready` high in cycle t+1+WAIT_CYCLES;
  - `stall` high in cycles t through t+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles. The processor presents the next request in the cycle after `ready`.
- Reset mid-operation: if `rst_n` is low on any edge in WAIT, the pending store is discarded, memory is cleared, and state returns to IDLE. Reset wins over a commit on the same edge.
- `err` is registered: it appears the cycle after the illegal sample and lasts one cycle.

## Test plan
- Reset: after reset, `rdata` = 0x00, `ready` = 0, `err` = 0, `stall` = 0 with no request. A load of every address returns 0x00.
- Store, WAIT_CYCLES = 2: `mem_write`=1, `addr`=3, `wdata`=0xA5 at cycle t.
  - `stall` = 1 in t..t+2; `ready` = 1 only at t+3; `rdata` is unchanged.
  - A following load of addr 3 returns 0xA5 with `ready` at t+3+4.
- Back-to-back: store 0x3C to addr 15, then load addr 15, then load addr 0. Expect `rdata` 0x3C, then 0x00, each on its own `ready` pulse 4 cycles apart.
- Illegal request: `mem_read` = `mem_write` = 1 with `addr`=5, `wdata`=0xFF for one cycle.
  - `err` pulses once, `ready` stays 0, `stall` stays 0.
  - A following load of addr 5 returns 0x00.
- Reset mid-store: store 0x77 to addr 2, then assert `rst_n`=0 in the first WAIT cycle.
  - Afterwards a load of addr 2 returns 0x00, and `ready` never pulsed for the aborted store.
- WAIT_CYCLES = 0 instance: store 0x12 to addr 1 at cycle t.
  - `stall` is high only in t; `ready` is high at t+1.
  - A following load of addr 1 returns 0x12 with `ready` at t+3.
